// File: rtl/universal_shift_reg_pkg.sv
// Shared definitions for the universal shift register: operating mode encodings.
package universal_shift_reg_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    function automatic logic is_shift(input mode_e m);
        return (m == MODE_SHR) || (m == MODE_SHL);
    endfunction

endpackage

// File: rtl/universal_shift_reg_d_ff_en.sv
// WIDTH-wide D register with synchronous active-high reset and clock enable.
module d_ff_en #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;

    // Stage storage: reset wins over enable, otherwise hold
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q <= '0;
        end else if (en_i) begin
            data_q <= d_i;
        end else begin
            data_q <= data_q;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/universal_shift_reg.sv
// Universal shift register: hold / shift right / shift left / parallel load over
// DEPTH stages of WIDTH bits, with a saturating count of written stages.
module universal_shift_reg
    import universal_shift_reg_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 3
) (
    input  logic                       cl,
    input  logic                       res,
    input  logic                       en,
    input  logic [1:0]                 mode,
    input  logic [WIDTH-1:0]           sin,
    input  logic [WIDTH*DEPTH-1:0]     pin,
    output logic [WIDTH-1:0]           sout_r,
    output logic [WIDTH-1:0]           sout_l,
    output logic [WIDTH*DEPTH-1:0]     pout,
    output logic [$clog2(DEPTH+1)-1:0] fill,
    output logic                       full
);

    localparam int FW = $clog2(DEPTH + 1);
    localparam logic [FW-1:0] FILL_MAX = FW'(DEPTH);

    mode_e                        mode_s;
    logic [DEPTH-1:0][WIDTH-1:0]  stage_q;
    logic [FW-1:0]                fill_q;
    logic [FW-1:0]                fill_d;
    logic                         full_q;

    assign mode_s = mode_e'(mode);

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic [WIDTH-1:0] shr_src_s;
        logic [WIDTH-1:0] shl_src_s;
        logic [WIDTH-1:0] nxt_s;

        if (i == 0) begin : g_shr_head
            assign shr_src_s = sin;
        end else begin : g_shr_body
            assign shr_src_s = stage_q[i-1];
        end

        if (i == DEPTH - 1) begin : g_shl_head
            assign shl_src_s = sin;
        end else begin : g_shl_body
            assign shl_src_s = stage_q[i+1];
        end

        // Per-stage next-value select
        always_comb begin
            nxt_s = stage_q[i];
            case (mode_s)
                MODE_HOLD: nxt_s = stage_q[i];
                MODE_SHR:  nxt_s = shr_src_s;
                MODE_SHL:  nxt_s = shl_src_s;
                MODE_LOAD: nxt_s = pin[i*WIDTH +: WIDTH];
                default:   nxt_s = stage_q[i];
            endcase
        end

        d_ff_en #(.WIDTH(WIDTH)) u_stage (
            .clk_i (cl),
            .rst_i (res),
            .en_i  (en),
            .d_i   (nxt_s),
            .q_o   (stage_q[i])
        );
    end

    // Fill count: each shift adds one stage of written data, a load fills all
    always_comb begin
        fill_d = fill_q;
        if (is_shift(mode_s)) begin
            if (fill_q != FILL_MAX) begin
                fill_d = fill_q + FW'(1);
            end else begin
                fill_d = fill_q;
            end
        end else if (mode_s == MODE_LOAD) begin
            fill_d = FILL_MAX;
        end else begin
            fill_d = fill_q;
        end
    end

    // Fill and full registers; full is precomputed so it is a flop output
    always_ff @(posedge cl) begin
        if (res) begin
            fill_q <= '0;
            full_q <= 1'b0;
        end else if (en) begin
            fill_q <= fill_d;
            full_q <= (fill_d == FILL_MAX);
        end else begin
            fill_q <= fill_q;
            full_q <= full_q;
        end
    end

    assign pout   = stage_q;
    assign sout_r = stage_q[DEPTH-1];
    assign sout_l = stage_q[0];
    assign fill   = fill_q;
    assign full   = full_q;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Self-checking bench: directed scenarios plus randomized traffic on a 1x3 and a
// 4x4 instance, both compared against a whole-vector arithmetic reference model.
module tb_universal_shift_reg;

    logic        cl = 1'b0;
    always #5 cl = ~cl;

    logic        r1, e1, s1;
    logic [1:0]  m1;
    logic [2:0]  p1, po1;
    logic        sr1, sl1, fu1;
    logic [1:0]  fi1;

    logic        r4, e4;
    logic [1:0]  m4;
    logic [3:0]  s4, sr4, sl4;
    logic [15:0] p4, po4;
    logic [2:0]  fi4;
    logic        fu4;

    logic [63:0] mp1, mp4;
    int          mf1, mf4;
    int          n_checks, n_fail;

    universal_shift_reg dut1 (
        .cl(cl), .res(r1), .en(e1), .mode(m1), .sin(s1), .pin(p1),
        .sout_r(sr1), .sout_l(sl1), .pout(po1), .fill(fi1), .full(fu1)
    );

    universal_shift_reg #(.WIDTH(4), .DEPTH(4)) dut4 (
        .cl(cl), .res(r4), .en(e4), .mode(m4), .sin(s4), .pin(p4),
        .sout_r(sr4), .sout_l(sl4), .pout(po4), .fill(fi4), .full(fu4)
    );

    // Whole register treated as one w*d-bit number; stage i is bits [i*w +: w]
    task automatic model_step(input int w, input int d, input logic r, input logic e,
                              input logic [1:0] m, input logic [63:0] s, input logic [63:0] p,
                              inout logic [63:0] pv, inout int f);
        logic [63:0] mask;
        mask = (64'd1 << (w * d)) - 64'd1;
        if (r) begin
            pv = 64'd0;
            f  = 0;
        end else if (e) begin
            case (m)
                2'b01: begin pv = ((pv << w) | s) & mask; f = (f < d) ? f + 1 : d; end
                2'b10: begin pv = (pv >> w) | (s << (w * (d - 1))); f = (f < d) ? f + 1 : d; end
                2'b11: begin pv = p & mask; f = d; end
                default: ;
            endcase
        end
    endtask

    task automatic set1(input logic r, input logic e, input logic [1:0] m, input logic s, input logic [2:0] p);
        r1 = r; e1 = e; m1 = m; s1 = s; p1 = p;
    endtask

    task automatic set4(input logic r, input logic e, input logic [1:0] m, input logic [3:0] s, input logic [15:0] p);
        r4 = r; e4 = e; m4 = m; s4 = s; p4 = p;
    endtask

    task automatic tick();
        @(posedge cl);
        model_step(1, 3, r1, e1, m1, {63'd0, s1}, {61'd0, p1}, mp1, mf1);
        model_step(4, 4, r4, e4, m4, {60'd0, s4}, {48'd0, p4}, mp4, mf4);
        #1;
    endtask

    task automatic test_reset();
        set1(1'b1, 1'b0, 2'b11, 1'b1, 3'b111);
        set4(1'b1, 1'b0, 2'b11, 4'hF, 16'hFFFF);
        tick();
        n_checks += 4;
        if (po1 !== 3'b000 || fi1 !== 2'd0 || fu1 !== 1'b0) begin
            n_fail++; $display("FAIL reset1: pout=%b fill=%0d full=%b, want 0/0/0", po1, fi1, fu1);
        end
        if (po4 !== 16'h0 || fi4 !== 3'd0 || fu4 !== 1'b0) begin
            n_fail++; $display("FAIL reset4: pout=%h fill=%0d full=%b, want 0/0/0", po4, fi4, fu4);
        end
        if (sr1 !== 1'b0 || sl1 !== 1'b0) begin
            n_fail++; $display("FAIL reset1_serial: sr=%b sl=%b, want 0/0", sr1, sl1);
        end
        if (sr4 !== 4'h0 || sl4 !== 4'h0) begin
            n_fail++; $display("FAIL reset4_serial: sr=%h sl=%h, want 0/0", sr4, sl4);
        end
    endtask

    task automatic test_shift_right_chain();
        logic [5:0] sins, want_sr;
        int         want_fill;
        sins    = 6'b001101;   // applied LSB first: 1,0,1,1,0,0
        want_sr = 6'b110100;   // LSB first: 0,0,1,0,1,1
        set1(1'b1, 1'b0, 2'b00, 1'b0, 3'b000); tick();
        for (int k = 0; k < 6; k++) begin
            set1(1'b0, 1'b1, 2'b01, sins[k], 3'b000);
            tick();
            want_fill = (k < 3) ? k + 1 : 3;
            n_checks += 2;
            if (sr1 !== want_sr[k]) begin
                n_fail++; $display("FAIL shr_sout_r edge %0d: got %b want %b", k + 1, sr1, want_sr[k]);
            end
            if (fi1 !== 2'(want_fill) || fu1 !== (k >= 2)) begin
                n_fail++; $display("FAIL shr_fill edge %0d: fill=%0d full=%b want %0d/%b", k + 1, fi1, fu1, want_fill, (k >= 2));
            end
        end
    endtask

    task automatic test_load_then_shift_left();
        set4(1'b1, 1'b0, 2'b00, 4'h0, 16'h0); tick();
        set4(1'b0, 1'b1, 2'b11, 4'h0, 16'hA5C3); tick();
        n_checks += 1;
        if (po4 !== 16'hA5C3 || fi4 !== 3'd4 || fu4 !== 1'b1) begin
            n_fail++; $display("FAIL load4: pout=%h fill=%0d full=%b want a5c3/4/1", po4, fi4, fu4);
        end
        set4(1'b0, 1'b1, 2'b10, 4'hF, 16'h0); tick();
        n_checks += 2;
        if (po4 !== 16'hFA5C || sl4 !== 4'hC) begin
            n_fail++; $display("FAIL shl4: pout=%h sout_l=%h want fa5c/c", po4, sl4);
        end
        if (fi4 !== 3'd4 || fu4 !== 1'b1 || sr4 !== 4'hF) begin
            n_fail++; $display("FAIL shl4_sat: fill=%0d full=%b sout_r=%h want 4/1/f", fi4, fu4, sr4);
        end
    endtask

    task automatic test_enable_and_hold();
        set1(1'b1, 1'b0, 2'b00, 1'b0, 3'b000); tick();
        set1(1'b0, 1'b1, 2'b11, 1'b0, 3'b101); tick();
        for (int k = 0; k < 5; k++) begin
            set1(1'b0, 1'b0, 2'b01, k[0], 3'b010);
            tick();
            n_checks += 1;
            if (po1 !== 3'b101 || fi1 !== 2'd3 || fu1 !== 1'b1) begin
                n_fail++; $display("FAIL en_low edge %0d: pout=%b fill=%0d want 101/3", k, po1, fi1);
            end
        end
        set1(1'b1, 1'b0, 2'b00, 1'b0, 3'b000); tick();
        set1(1'b0, 1'b1, 2'b01, 1'b1, 3'b000); tick();
        for (int k = 0; k < 3; k++) begin
            set1(1'b0, 1'b1, 2'b00, 1'b0, 3'b110);
            tick();
            n_checks += 1;
            if (po1 !== 3'b001 || fi1 !== 2'd1 || fu1 !== 1'b0) begin
                n_fail++; $display("FAIL hold_mode edge %0d: pout=%b fill=%0d want 001/1", k, po1, fi1);
            end
        end
    endtask

    task automatic test_reset_mid_shift();
        set1(1'b1, 1'b0, 2'b00, 1'b0, 3'b000); tick();
        set1(1'b0, 1'b1, 2'b01, 1'b1, 3'b000); tick(); tick();
        n_checks += 1;
        if (po1 !== 3'b011 || fi1 !== 2'd2) begin
            n_fail++; $display("FAIL pre_reset: pout=%b fill=%0d want 011/2", po1, fi1);
        end
        set1(1'b1, 1'b1, 2'b01, 1'b1, 3'b000); tick();
        n_checks += 1;
        if (po1 !== 3'b000 || fi1 !== 2'd0 || fu1 !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset: pout=%b fill=%0d full=%b want 000/0/0", po1, fi1, fu1);
        end
    endtask

    task automatic test_direction_change();
        set1(1'b1, 1'b0, 2'b00, 1'b0, 3'b000); tick();
        set1(1'b0, 1'b1, 2'b01, 1'b1, 3'b000); tick();
        set1(1'b0, 1'b1, 2'b01, 1'b0, 3'b000); tick();
        set1(1'b0, 1'b1, 2'b10, 1'b1, 3'b000); tick();
        n_checks += 1;
        if (po1 !== 3'b101 || fi1 !== 2'd3 || fu1 !== 1'b1) begin
            n_fail++; $display("FAIL dir_change: pout=%b fill=%0d full=%b want 101/3/1", po1, fi1, fu1);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            set1(($urandom_range(0, 19) == 0), ($urandom_range(0, 4) != 0), 2'($urandom),
                 1'($urandom), 3'($urandom));
            set4(($urandom_range(0, 19) == 0), ($urandom_range(0, 4) != 0), 2'($urandom),
                 4'($urandom), 16'($urandom));
            tick();
            n_checks += 4;
            if (po1 !== mp1[2:0] || sr1 !== mp1[2] || sl1 !== mp1[0]) begin
                n_fail++; $display("FAIL rand1_data cyc %0d: pout=%b want %b", k, po1, mp1[2:0]);
            end
            if (fi1 !== 2'(mf1) || fu1 !== (mf1 == 3)) begin
                n_fail++; $display("FAIL rand1_fill cyc %0d: fill=%0d full=%b want %0d", k, fi1, fu1, mf1);
            end
            if (po4 !== mp4[15:0] || sr4 !== mp4[15:12] || sl4 !== mp4[3:0]) begin
                n_fail++; $display("FAIL rand4_data cyc %0d: pout=%h want %h", k, po4, mp4[15:0]);
            end
            if (fi4 !== 3'(mf4) || fu4 !== (mf4 == 4)) begin
                n_fail++; $display("FAIL rand4_fill cyc %0d: fill=%0d full=%b want %0d", k, fi4, fu4, mf4);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        mp1 = 64'd0; mp4 = 64'd0; mf1 = 0; mf4 = 0;
        set1(1'b1, 1'b0, 2'b00, 1'b0, 3'b000);
        set4(1'b1, 1'b0, 2'b00, 4'h0, 16'h0);
        test_reset();
        test_shift_right_chain();
        test_load_then_shift_left();
        test_enable_and_hold();
        test_reset_mid_shift();
        test_direction_change();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/universal_shift_reg.md
UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

Interface
REQ-001 Parameter SHALL be: WIDTH, 1, bits per stage (>=1).
REQ-002 Parameter SHALL be: DEPTH, 3, number of stages (>=2).
REQ-003 Port SHALL be: cl  input  1  single clock, all state updates on rising edge.
REQ-004 Port SHALL be: res  input  1  synchronous, active-high reset.
REQ-005 Port SHALL be: en  input  1  clock enable; when 0, all state holds regardless of mode.
REQ-006 Port SHALL be: mode  input  2  operation: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-007 Port SHALL be: sin  input  WIDTH  serial data in, used by both shift directions.
REQ-008 Port SHALL be: pin  input  WIDTH*DEPTH  parallel load data; slice [i*WIDTH +: WIDTH] targets stage i.
REQ-009 Port SHALL be: sout_r  output  WIDTH  stage DEPTH-1, the right-shift serial output.
REQ-010 Port SHALL be: sout_l  output  WIDTH  stage 0, the left-shift serial output.
REQ-011 Port SHALL be: pout  output  WIDTH*DEPTH  all stages; slice i = stage i.
REQ-012 Port SHALL be: fill  output  $clog2(DEPTH+1)  count of stages holding written data.
REQ-013 Port SHALL be: full  output  1  high when fill == DEPTH.

Function
REQ-014 Active edge SHALL be a rising edge of cl with res=0 and en=1; only active edges change stages or fill.
REQ-015 Shift right SHALL load stage 0 <- sin and stage i <- stage i-1 for i=1..DEPTH-1.
REQ-016 Shift left SHALL load stage DEPTH-1 <- sin and stage i <- stage i+1 for i=0..DEPTH-2.
REQ-017 Parallel load SHALL load every stage from its pin slice in one edge.
REQ-018 Hold mode SHALL leave stages and fill unchanged even with en=1.
REQ-019 Latency: a value on sin at a shift-right active edge SHALL appear on sout_r after exactly DEPTH active shift-right edges; the shift-left equivalent SHALL appear on sout_l.
REQ-020 With WIDTH=1, DEPTH=3, mode=01 and en=1, the block SHALL be cycle-equivalent to a 3-stage serial D-flip-flop chain.
REQ-021 Outputs SHALL be registered stage values, never combinational from sin or pin.
REQ-022 Each shift (either direction) SHALL increment fill by 1, saturating at DEPTH.
REQ-023 Parallel load SHALL set fill to DEPTH.
REQ-024 A direction change mid-stream SHALL be legal: data reverses order, and fill continues to increment and saturate.
REQ-025 en=0 SHALL take priority over mode; res SHALL take priority over en and mode.

Reset
REQ-026 On an active edge with res=1, all stages SHALL become 0, fill SHALL become 0, and full SHALL become 0.
REQ-027 Reset asserted mid-shift SHALL discard in-flight data within that same edge, with no partial update.
REQ-028 State before the first reset is undefined; the bench SHALL apply reset before checking outputs.

Structure
REQ-029 The shared package SHALL hold the mode encodings MODE_HOLD, MODE_SHR, MODE_SHL and MODE_LOAD.
REQ-030 One sub-module SHALL be used, d_ff_en: a WIDTH-wide D register with synchronous reset and enable, instantiated DEPTH times via generate.
REQ-031 Next-state mux per stage and the fill counter SHALL live in universal_shift_reg.

Verification
REQ-032 Defaults, reset, mode=01, sin sequence 1,0,1,1 -> sout_r = 0,0,1,0,1,1 starting at the third edge; fill = 1,2,3,3; full at the third edge.
REQ-033 WIDTH=4, DEPTH=4, mode=11, pin=16'hA5C3 -> next edge pout=16'hA5C3, fill=4, full=1; then mode=10, sin=4'hF -> pout=16'hFA5C, sout_l=4'hC.
REQ-034 Defaults, load 3'b101, then en=0 with mode=01 for 5 edges -> pout stays 3'b101, fill stays 3.
REQ-035 Defaults, two shift-right edges with sin=1, then res=1 for one edge while mode=01 -> pout=0, fill=0, full=0 on that edge.
REQ-036 Defaults, shift right sin=1 then 0, then shift left sin=1 -> pout=3'b101; fill=3, full=1.
